// File: rtl/ss_sequencer.sv
// Save-state sequencer: walks every device on the ss2device_if bus in index
// order. It either streams each device's header and contents out (save) or
// streams them back in and writes them into the devices (restore).
`timescale 1ns/1ps
module ss_sequencer #(
    parameter int COUNT   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_save,
    input  logic              start_restore,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [63:0]       ss_data,
    output logic [23:0]       ss_addr,
    output logic [COUNT-1:0]  ss_select,
    output logic              ss_write,
    output logic              ss_read,
    output logic              ss_query,
    input  logic [63:0]       ss_data_in [COUNT],
    input  logic [COUNT-1:0]  ss_ack,
    output logic [63:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [63:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready
);

    // state  | meaning
    // IDLE   | waiting for a start pulse
    // QUERY  | ss_query strobe to current device, waiting for ack or timeout
    // QWAIT  | strobe gap after query ack; skip device if it holds no words
    // HDR    | save: offer header on out_data; restore: take and check header
    // XFER   | strobe gap; restore also waits here for the next in_data word
    // XWAIT  | ss_read (save) or ss_write (restore) strobe, waiting for ack
    // STREAM | save: offer the word just read on out_data
    // NEXT   | strobe gap; advance to the next device or finish
    // FINISH | one-cycle done pulse

    localparam int          IW   = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [7:0]  TMO  = 8'(TIMEOUT);
    localparam logic [24:0] MAXW = 25'h100_0000;

    typedef enum logic [3:0] {
        IDLE, QUERY, QWAIT, HDR, XFER, XWAIT, STREAM, NEXT, FINISH
    } state_t;

    state_t        state, state_nxt;
    logic          save_mode;
    logic [IW-1:0] idx;
    logic [24:0]   words;
    logic [39:0]   hdr_key;
    logic [7:0]    timer;

    logic          ack_cur;
    logic          tmo_hit;
    logic          last_word;
    logic          last_dev;
    logic          hdr_match;
    logic [31:0]   q_count;
    logic [24:0]   q_words;

    assign ack_cur   = ss_ack[idx];
    assign tmo_hit   = (timer == 8'd1) && !ack_cur;
    assign last_word = (({1'b0, ss_addr} + 25'd1) == words);
    assign last_dev  = (idx == IW'(COUNT - 1));
    assign hdr_match = ({in_data[63:56], in_data[31:0]} == hdr_key);
    assign q_count   = ss_data_in[idx][31:0];
    // The address bus is 24 bits wide, so larger devices are truncated.
    assign q_words   = (q_count > 32'h0100_0000) ? MAXW : q_count[24:0];

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and decoded outputs; error is asserted in the same cycle the
    // FSM decides to abort so busy falls on the following cycle.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        error     = 1'b0;
        ss_query  = 1'b0;
        ss_read   = 1'b0;
        ss_write  = 1'b0;
        ss_select = '0;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_save || start_restore) state_nxt = QUERY;
            end
            QUERY: begin
                ss_query  = 1'b1;
                ss_select = COUNT'(1) << idx;
                if (ack_cur)      state_nxt = QWAIT;
                else if (tmo_hit) state_nxt = NEXT;
            end
            QWAIT: begin
                state_nxt = (words == '0) ? NEXT : HDR;
            end
            HDR: begin
                if (save_mode) begin
                    out_valid = 1'b1;
                    if (out_ready) state_nxt = XFER;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (hdr_match) begin
                            state_nxt = XFER;
                        end else begin
                            error     = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            XFER: begin
                if (save_mode) begin
                    state_nxt = XWAIT;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) state_nxt = XWAIT;
                end
            end
            XWAIT: begin
                ss_read   = save_mode;
                ss_write  = !save_mode;
                ss_select = COUNT'(1) << idx;
                if (ack_cur) begin
                    if (save_mode)      state_nxt = STREAM;
                    else if (last_word) state_nxt = NEXT;
                    else                state_nxt = XFER;
                end else if (tmo_hit) begin
                    error     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_word ? NEXT : XFER;
            end
            NEXT: begin
                state_nxt = last_dev ? FINISH : QUERY;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: run mode, device index, header, ack timer and bus/stream words.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            save_mode <= 1'b0;
            idx       <= '0;
            words     <= '0;
            hdr_key   <= '0;
            timer     <= '0;
            ss_addr   <= '0;
            ss_data   <= '0;
            out_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_save || start_restore) begin
                        save_mode <= start_save;
                        idx       <= '0;
                        ss_addr   <= '0;
                        timer     <= TMO;
                    end
                end
                QUERY: begin
                    if (ack_cur) begin
                        words   <= q_words;
                        hdr_key <= {ss_data_in[idx][63:56], q_count};
                        if (save_mode) out_data <= ss_data_in[idx];
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                XFER: begin
                    timer <= TMO;
                    if (!save_mode && in_valid) ss_data <= in_data;
                end
                XWAIT: begin
                    if (ack_cur) begin
                        if (save_mode) out_data <= ss_data_in[idx];
                        else           ss_addr  <= ss_addr + 24'd1;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                STREAM: begin
                    if (out_ready) ss_addr <= ss_addr + 24'd1;
                end
                NEXT: begin
                    idx     <= idx + IW'(1);
                    ss_addr <= '0;
                    timer   <= TMO;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_sequencer.sv
// Randomized bench for ss_sequencer: behavioural devices plus a record-level
// model of the save/restore streams, with protocol monitors running each cycle.
`timescale 1ns/1ps
module tb_ss_sequencer;

    localparam int N    = 2;
    localparam int MAXC = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start_save = 1'b0, start_restore = 1'b0;
    logic              busy, done, error;
    logic [63:0]       ss_data;
    logic [23:0]       ss_addr;
    logic [N-1:0]      ss_select;
    logic              ss_write, ss_read, ss_query;
    logic [63:0]       ss_data_in [N];
    logic [N-1:0]      ss_ack = '0;
    logic [63:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [63:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;

    ss_sequencer #(.COUNT(N), .TIMEOUT(255)) dut (
        .clock(clock), .reset_n(reset_n),
        .start_save(start_save), .start_restore(start_restore),
        .busy(busy), .done(done), .error(error),
        .ss_data(ss_data), .ss_addr(ss_addr), .ss_select(ss_select),
        .ss_write(ss_write), .ss_read(ss_read), .ss_query(ss_query),
        .ss_data_in(ss_data_in), .ss_ack(ss_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;

    // device configuration
    bit          dev_present [N];
    bit          dev_nack    [N];
    int          dev_count   [N];
    logic [63:0] dev_mem     [N][MAXC];

    // stimulus knobs
    int ready_mode = 1;    // 0 random, 1 always ready, 2 never ready
    bit in_gap     = 1'b0;
    int max_lat    = 3;

    // observations
    logic [63:0] obs_stream[$];
    logic [95:0] obs_wr[$];
    logic [63:0] in_q[$];
    int n_done, n_error, n_read, n_write;
    int q_cyc [N];

    // expectations
    logic [63:0] exp_stream[$];
    logic [95:0] exp_wr[$];
    bit          exp_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr_word(input int d);
        return {8'(d), 22'd0, 2'b11, 32'(dev_count[d])};
    endfunction

    function automatic int sel_idx(input logic [N-1:0] s);
        for (int i = 0; i < N; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic logic strb();
        return ss_query | ss_read | ss_write;
    endfunction

    // Reference: save emits header + contents of every present, non-empty device.
    task automatic model_save();
        exp_stream.delete(); exp_wr.delete(); exp_err = 1'b0;
        for (int d = 0; d < N; d++) begin
            if (!dev_present[d] || dev_count[d] == 0) continue;
            exp_stream.push_back(hdr_word(d));
            if (dev_nack[d]) begin exp_err = 1'b1; break; end
            for (int a = 0; a < dev_count[d]; a++) exp_stream.push_back(dev_mem[d][a]);
        end
    endtask

    // Reference: restore consumes one header per such device, then its words.
    task automatic model_restore();
        int p;
        p = 0;
        exp_stream.delete(); exp_wr.delete(); exp_err = 1'b0;
        for (int d = 0; d < N; d++) begin
            if (!dev_present[d] || dev_count[d] == 0) continue;
            if (p >= in_q.size() || in_q[p][63:56] != 8'(d) || in_q[p][31:0] != 32'(dev_count[d])) begin
                exp_err = 1'b1; break;
            end
            p++;
            if (dev_nack[d]) begin exp_err = 1'b1; break; end
            for (int a = 0; a < dev_count[d]; a++) begin
                exp_wr.push_back({8'(d), 24'(a), in_q[p]});
                p++;
            end
        end
    endtask

    // Devices, stream drivers and protocol monitors.
    initial begin : bfm
        int lat, d;
        bit prev_ack, prev_err, prev_hold, prev_strb, tog;
        logic [63:0] prev_out;
        lat = 0; prev_ack = 0; prev_err = 0; prev_hold = 0; prev_strb = 0; tog = 0; prev_out = '0;
        for (int i = 0; i < N; i++) ss_data_in[i] = '0;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (prev_ack)  check("strobe_low_after_ack", 64'(strb()), 64'd0);
                if (prev_err)  check("busy_low_after_error", 64'(busy), 64'd0);
                if (prev_hold) begin
                    check("out_valid_held", 64'(out_valid), 64'd1);
                    check("out_data_stable", out_data, prev_out);
                end
                if (strb() && !prev_strb) begin
                    check("select_onehot", 64'($countones(ss_select)), 64'd1);
                    if (ss_read)  n_read++;
                    if (ss_write) n_write++;
                end
                if (ss_query) q_cyc[sel_idx(ss_select)]++;
                if (done)  n_done++;
                if (error) n_error++;
                if (out_valid && out_ready) obs_stream.push_back(out_data);
                if (in_valid && in_ready && in_q.size() > 0) void'(in_q.pop_front());
                if (ss_write && (ss_ack & ss_select) != '0)
                    obs_wr.push_back({8'(sel_idx(ss_select)), ss_addr, ss_data});
                prev_ack  = strb() && ((ss_ack & ss_select) != '0);
                prev_err  = error;
                prev_hold = out_valid && !out_ready;
                prev_out  = out_data;
                prev_strb = strb();
            end else begin
                prev_ack = 0; prev_err = 0; prev_hold = 0; prev_strb = 0;
            end
            @(posedge clock); #1;
            ss_ack = '0;
            if (strb()) begin
                d = sel_idx(ss_select);
                if (ss_query ? dev_present[d] : !dev_nack[d]) begin
                    if (lat == 0) begin
                        ss_ack[d] = 1'b1;
                        if (ss_query) ss_data_in[d] = hdr_word(d);
                        else if (ss_read && ss_addr < MAXC) ss_data_in[d] = dev_mem[d][ss_addr];
                        lat = $urandom_range(0, max_lat);
                    end else begin
                        lat--;
                    end
                end
            end else begin
                lat = $urandom_range(0, max_lat);
            end
            out_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            tog = !tog;
            if (in_q.size() > 0) begin
                in_valid = in_gap ? tog : ($urandom_range(0, 3) != 0);
                in_data  = in_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"},     64'(busy),      64'd0);
        check({tag, "_done"},     64'(done),      64'd0);
        check({tag, "_error"},    64'(error),     64'd0);
        check({tag, "_strobes"},  64'({ss_query, ss_read, ss_write}), 64'd0);
        check({tag, "_select"},   64'(ss_select), 64'd0);
        check({tag, "_out_valid"},64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready),  64'd0);
        check({tag, "_ss_addr"},  64'(ss_addr),   64'd0);
        check({tag, "_ss_data"},  ss_data,        64'd0);
        check({tag, "_out_data"}, out_data,       64'd0);
    endtask

    task automatic run(input string tag, input bit save, input bit both, input bit hold);
        int cyc, hold_cnt;
        logic [63:0] held;
        if (save || both) model_save(); else model_restore();
        obs_stream.delete(); obs_wr.delete();
        n_done = 0; n_error = 0; n_read = 0; n_write = 0;
        for (int i = 0; i < N; i++) q_cyc[i] = 0;
        @(negedge clock);
        start_save = save | both; start_restore = !save | both;
        @(negedge clock);
        start_save = 0; start_restore = 0;
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        cyc = 0; hold_cnt = 0; held = '0;
        while (busy && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            if (cyc == 3 && busy) begin start_save = 1; start_restore = 1; end
            else begin start_save = 0; start_restore = 0; end
            if (hold) begin
                if (ready_mode == 1 && hold_cnt == 0 && obs_stream.size() >= 2) begin
                    ready_mode = 2;
                end else if (ready_mode == 2 && out_valid && !out_ready) begin
                    if (hold_cnt == 0) held = out_data;
                    check({tag, "_hold_data"}, out_data, held);
                    check({tag, "_no_read_in_hold"}, 64'(ss_read), 64'd0);
                    hold_cnt++;
                    if (hold_cnt == 10) ready_mode = 1;
                end
            end
        end
        start_save = 0; start_restore = 0;
        check({tag, "_finished"}, 64'(busy), 64'd0);
        repeat (2) @(negedge clock);
        if (hold) check({tag, "_hold_cycles"}, 64'(hold_cnt), 64'd10);
        check({tag, "_stream_len"}, 64'(obs_stream.size()), 64'(exp_stream.size()));
        for (int i = 0; i < exp_stream.size() && i < obs_stream.size(); i++)
            check({tag, "_stream_word"}, obs_stream[i], exp_stream[i]);
        check({tag, "_write_count"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            check({tag, "_write_addr"}, 64'(obs_wr[i][87:64]), 64'(exp_wr[i][87:64]));
            check({tag, "_write_data"}, obs_wr[i][63:0], exp_wr[i][63:0]);
        end
        check({tag, "_done"},  64'(n_done),  64'(!exp_err));
        check({tag, "_error"}, 64'(n_error), 64'(exp_err));
        if (save || both) check({tag, "_no_writes"}, 64'(n_write), 64'd0);
        else              check({tag, "_no_reads"},  64'(n_read),  64'd0);
        in_q.delete();
    endtask

    task automatic fill_mem();
        for (int d = 0; d < N; d++)
            for (int a = 0; a < MAXC; a++) dev_mem[d][a] = {$urandom, $urandom};
    endtask

    task automatic build_in(input bit corrupt);
        logic [63:0] w;
        in_q.delete();
        for (int d = 0; d < N; d++) begin
            if (!dev_present[d] || dev_count[d] == 0) continue;
            w = hdr_word(d);
            if (corrupt && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) w[63:56] = w[63:56] ^ 8'd1;
                else                           w[31:0]  = w[31:0] + 32'd1;
            end
            in_q.push_back(w);
            for (int a = 0; a < dev_count[d]; a++) in_q.push_back({$urandom, $urandom});
        end
    endtask

    initial begin : main
        int cyc;
        for (int d = 0; d < N; d++) begin
            dev_present[d] = 1; dev_nack[d] = 0; dev_count[d] = 0; q_cyc[d] = 0;
        end
        fill_mem();
        repeat (3) @(negedge clock);
        check_idle("in_reset");
        reset_n = 1;
        @(negedge clock);
        check_idle("after_reset");

        dev_count[0] = 3; dev_count[1] = 0; ready_mode = 1;
        run("save_basic", 1, 0, 0);
        run("start_both", 1, 1, 0);
        run("save_hold", 1, 0, 1);

        dev_count[0] = 2; dev_present[1] = 0; ready_mode = 0;
        run("absent_dev", 1, 0, 0);
        check("query_timeout_cycles", 64'(q_cyc[1]), 64'd255);
        dev_present[1] = 1; dev_count[1] = 0;

        in_q.delete(); in_q.push_back({8'd1, 22'd0, 2'b11, 32'd2});
        run("hdr_mismatch", 0, 0, 0);

        in_gap = 1;
        in_q.delete(); in_q.push_back(hdr_word(0));
        in_q.push_back({$urandom, $urandom}); in_q.push_back({$urandom, $urandom});
        run("restore_gap", 0, 0, 0);
        in_gap = 0;

        dev_nack[0] = 1;
        run("read_timeout", 1, 0, 0);
        build_in(0);
        run("write_timeout", 0, 0, 0);
        dev_nack[0] = 0;

        dev_count[0] = 3; ready_mode = 1;
        @(negedge clock); start_save = 1;
        @(negedge clock); start_save = 0;
        cyc = 0;
        while (!(ss_read && ss_addr == 24'd1) && cyc < 500) begin @(negedge clock); cyc++; end
        check("reached_second_read", 64'(ss_read), 64'd1);
        #2 reset_n = 0;
        #1 check_idle("abort_reset");
        repeat (2) @(negedge clock);
        n_done = 0; n_error = 0;
        reset_n = 1;
        repeat (5) @(negedge clock);
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_no_error", 64'(n_error), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        run("save_after_abort", 1, 0, 0);

        for (int it = 0; it < 24; it++) begin
            bit save;
            for (int d = 0; d < N; d++) begin
                dev_present[d] = ($urandom_range(0, 5) != 0);
                dev_count[d]   = $urandom_range(0, MAXC);
                dev_nack[d]    = ($urandom_range(0, 9) == 0);
            end
            fill_mem();
            max_lat    = $urandom_range(0, 4);
            ready_mode = $urandom_range(0, 1);
            in_gap     = 1'($urandom_range(0, 1));
            save       = 1'($urandom_range(0, 1));
            if (!save) build_in($urandom_range(0, 3) == 0);
            run("random", save, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
